// File: rtl/pipe_pkg.sv
// Shared pipeline definitions used by the decode unit, EX and the hazard sequencer.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] FUNCT_ADD = 6'b000000;
  localparam logic [5:0] FUNCT_SUB = 6'b000001;
  localparam logic [5:0] FUNCT_MUL = 6'b000010;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Free-running up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;

  // count enabled cycles until the ceiling is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage sequencer: load-use stall, multi-cycle MUL freeze, taken-branch squash
// and a saturating count of PC-stall cycles.
module ex_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rt,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic [1:0]            id_ALUOp,
  input  logic [5:0]            id_funct,
  input  logic                  ex_branch_taken,
  output logic                  stall_flag,
  output logic                  pc_stall,
  output logic                  bubble,
  output logic                  flush,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int              MC_W      = $clog2(MUL_LAT) + 1;
  localparam logic [MC_W-1:0] MC_LOAD   = MC_W'(MUL_LAT - 1);
  localparam logic [MC_W-1:0] MC_ONE    = MC_W'(1);
  localparam bit              MUL_MULTI = (MUL_LAT > 1);

  state_e                  state_q, state_d;
  logic [MC_W-1:0]         mul_cnt_q, mul_cnt_d;
  logic                    ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0]   ex_rd_q, ex_rd_d;
  logic                    ex_load_q, ex_load_d;
  logic                    is_mul;
  logic                    hazard_lu;

  assign is_mul = id_valid && (id_ALUOp == ALUOP_RTYPE) && (id_funct == FUNCT_MUL);

  // r0 is hard-wired zero, so a load into it can never feed a consumer
  assign hazard_lu = ex_valid_q && ex_load_q && (ex_rd_q != {REG_ADDR_W{1'b0}}) && id_valid &&
                     ((ex_rd_q == id_rs) || (id_uses_rt && (ex_rd_q == id_rt)));

  // next-state and pipeline control, branch beats load-use beats MUL issue
  always_comb begin
    state_d    = state_q;
    mul_cnt_d  = mul_cnt_q;
    ex_valid_d = ex_valid_q;
    ex_rd_d    = ex_rd_q;
    ex_load_d  = ex_load_q;
    stall_flag = 1'b0;
    pc_stall   = 1'b0;
    bubble     = 1'b0;
    flush      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ex_branch_taken) begin
          flush      = 1'b1;
          bubble     = 1'b1;
          ex_valid_d = 1'b0;
        end else if (hazard_lu) begin
          pc_stall   = 1'b1;
          bubble     = 1'b1;
          ex_valid_d = 1'b0;
        end else begin
          ex_valid_d = id_valid;
          ex_rd_d    = id_rd;
          ex_load_d  = id_mem_read && id_reg_write;
          if (is_mul && MUL_MULTI) begin
            state_d   = ST_MUL_BUSY;
            mul_cnt_d = MC_LOAD;
          end else begin
            state_d   = ST_RUN;
          end
        end
      end
      ST_MUL_BUSY: begin
        // EX is frozen, so it cannot resolve a branch here
        stall_flag = 1'b1;
        pc_stall   = 1'b1;
        mul_cnt_d  = mul_cnt_q - MC_ONE;
        if (mul_cnt_q == MC_ONE) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_MUL_BUSY;
        end
      end
      default: begin
        state_d   = ST_RUN;
        mul_cnt_d = {MC_W{1'b0}};
      end
    endcase
  end

  // state and EX shadow registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      mul_cnt_q  <= {MC_W{1'b0}};
      ex_valid_q <= 1'b0;
      ex_rd_q    <= {REG_ADDR_W{1'b0}};
      ex_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mul_cnt_q  <= mul_cnt_d;
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      ex_load_q  <= ex_load_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (pc_stall),
    .cnt_o (stall_cnt)
  );

endmodule
